// File: rtl/cke_sched.sv
// cke_sched: N-channel clock-enable scheduler gated on a qualified MMCM lock, with start/stop run control.
// Defining CKE_SCHED_STALL_EN adds an i_stall input that pauses the whole schedule while in RUN.
module cke_sched #(
    parameter int N_CH       = 3,
    parameter int CNT_W      = 8,
    parameter int TICK_W     = 32,
    parameter int LOCK_WAIT  = 16,
    parameter int DEF_PERIOD = 4,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              i_clk_sys,
    input  logic              i_rst_n,
    input  logic              i_locked,
    input  logic              i_start,
    input  logic              i_stop,
`ifdef CKE_SCHED_STALL_EN
    input  logic              i_stall,
`endif
    input  logic              i_cfg_wr,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [CNT_W-1:0]  i_cfg_period,
    input  logic [CNT_W-1:0]  i_cfg_phase,
    output logic              o_cfg_err,
    output logic              o_running,
    output logic [N_CH-1:0]   o_cke,
    output logic [TICK_W-1:0] o_tick_cnt
);

    localparam int LK_W = $clog2(LOCK_WAIT + 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK,
        S_IDLE,
        S_RUN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_lk_meta;
    logic              r_lk_s;
    logic [LK_W-1:0]   r_lock_cnt;
    logic [CNT_W-1:0]  r_period [N_CH];
    logic [CNT_W-1:0]  r_phase  [N_CH];
    logic [CNT_W-1:0]  r_cnt    [N_CH];
    logic [CNT_W-1:0]  w_cnt_nxt [N_CH];
    logic [N_CH-1:0]   w_cke_nxt;
    logic              w_stall;
    logic              w_cfg_valid;
    logic              w_wr_ok;
    logic              w_run_entry;
    logic              w_advance;

`ifdef CKE_SCHED_STALL_EN
    assign w_stall = i_stall;
`else
    assign w_stall = 1'b0;
`endif

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lk_meta <= 1'b0;
            r_lk_s    <= 1'b0;
        end else begin
            r_lk_meta <= i_locked;
            r_lk_s    <= r_lk_meta;
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock_cnt <= '0;
        end else if (!r_lk_s || r_state != S_WAIT_LOCK) begin
            r_lock_cnt <= '0;
        end else begin
            r_lock_cnt <= r_lock_cnt + LK_W'(1);
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_WAIT_LOCK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Loss of lock dominates everything; stop dominates start and stall.
    always_comb begin
        w_state_nxt = r_state;
        if (!r_lk_s) begin
            w_state_nxt = S_WAIT_LOCK;
        end else begin
            case (r_state)
                S_WAIT_LOCK: if (r_lock_cnt == LK_W'(LOCK_WAIT - 1)) w_state_nxt = S_IDLE;
                S_IDLE:      if (i_start && !i_stop) w_state_nxt = S_RUN;
                S_RUN:       if (i_stop) w_state_nxt = S_IDLE;
                default:     w_state_nxt = S_WAIT_LOCK;
            endcase
        end
    end

    assign w_cfg_valid = (32'(i_cfg_ch) < N_CH) &&
                         ((i_cfg_period == '0) || (i_cfg_phase < i_cfg_period));
    assign w_wr_ok     = i_cfg_wr && (r_state == S_IDLE) && w_cfg_valid;
    assign w_run_entry = (r_state == S_IDLE) && (w_state_nxt == S_RUN);
    assign w_advance   = (r_state == S_RUN) && (w_state_nxt == S_RUN) && !w_stall;

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_period[i] <= CNT_W'(DEF_PERIOD);
                r_phase[i]  <= '0;
            end
        end else if (w_wr_ok) begin
            for (int i = 0; i < N_CH; i++) begin
                if (i_cfg_ch == CH_W'(i)) begin
                    r_period[i] <= i_cfg_period;
                    r_phase[i]  <= i_cfg_phase;
                end
            end
        end
    end

    // Counters hold the RUN cycle index modulo P for the cycle being presented,
    // so enables are computed one cycle early from the next counter value.
    always_comb begin
        w_cke_nxt = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
        end
        for (int i = 0; i < N_CH; i++) begin
            if (w_run_entry) begin
                w_cnt_nxt[i] = '0;
            end else if (w_advance) begin
                if (r_period[i] <= ONE || r_cnt[i] == r_period[i] - ONE) begin
                    w_cnt_nxt[i] = '0;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + ONE;
                end
            end
            if ((w_run_entry || w_advance) && r_period[i] != '0 &&
                w_cnt_nxt[i] == r_phase[i]) begin
                w_cke_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
            o_cke      <= '0;
            o_running  <= 1'b0;
            o_cfg_err  <= 1'b0;
            o_tick_cnt <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            o_cke     <= w_cke_nxt;
            o_running <= (w_state_nxt == S_RUN);
            o_cfg_err <= i_cfg_wr && !w_wr_ok;
            if (w_run_entry) begin
                o_tick_cnt <= '0;
            end else if (w_advance) begin
                o_tick_cnt <= o_tick_cnt + TICK_W'(1);
            end
        end
    end

endmodule
